sram_arbiter: RTL and testbench

//  Owns the external async SRAM pins (RAMCS_b/RAMOE_b/RAMWE_b, ADR, DAT) for the Atom core.
//  Two requesters: CPU (read/write) and video fetch (read only); one access at a time.

---
 rtl/atom_mem_pkg.sv | 21 ++
 rtl/sram_rr_arbiter.sv | 33 +++
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atom_mem_pkg.sv
// Shared types and default widths for the Atom external SRAM path.
package atom_mem_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        DONE
    } sram_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_VID
    } owner_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant between CPU and video; remembers who was served last.
module sram_rr_arbiter
    import atom_mem_pkg::*;
(
    input  logic clk,
    input  logic reset_b,
    input  logic cpu_req,
    input  logic vid_req,
    input  logic grant_en,
    output logic grant,
    output logic grant_vid
);

    owner_t last_grant;

    // On contention the requester that was not served last wins, so neither can starve.
    always_comb begin
        grant     = grant_en && (cpu_req || vid_req);
        grant_vid = vid_req;
        if (cpu_req && vid_req) begin
            grant_vid = (last_grant == OWN_CPU);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            last_grant <= OWN_CPU;
        end else if (grant) begin
            last_grant <= grant_vid ? OWN_VID : OWN_CPU;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Owns the async SRAM pins for the Atom core and serialises CPU and video accesses,
// generating registered strobes and one-cycle completion acks.
module sram_arbiter
    import atom_mem_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    output logic              RAMCS_b,
    output logic              RAMOE_b,
    output logic              RAMWE_b,
    output logic [ADDR_W-1:0] ADR,
    inout  wire  [DATA_W-1:0] DAT
);

    sram_state_t       state_q;
    sram_state_t       state_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    owner_t            owner_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_en;
    logic              grant;
    logic              grant_vid;
    logic              grant_we;

    sram_rr_arbiter u_rr (
        .clk       (clk),
        .reset_b   (reset_b),
        .cpu_req   (cpu_req),
        .vid_req   (vid_req),
        .grant_en  (state_q == IDLE),
        .grant     (grant),
        .grant_vid (grant_vid)
    );

    assign grant_we = !grant_vid && cpu_we;
    assign DAT      = drive_en ? wdata_q : 'z;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = grant_we ? WR_SETUP : RD;
                    cnt_d   = '0;
                end
            end
            RD: begin
                if (cnt_q == 8'(RD_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_STROBE;
                cnt_d   = '0;
            end
            WR_STROBE: begin
                if (cnt_q == 8'(WR_CYCLES - 1)) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state so every strobe leaves a flop, never a gate.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_CPU;
            wdata_q   <= '0;
            ADR       <= '0;
            RAMCS_b   <= 1'b1;
            RAMOE_b   <= 1'b1;
            RAMWE_b   <= 1'b1;
            drive_en  <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
            cpu_rdata <= '0;
            vid_rdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                owner_q <= grant_vid ? OWN_VID : OWN_CPU;
                ADR     <= grant_vid ? vid_addr : cpu_addr;
                wdata_q <= cpu_wdata;
            end
            RAMCS_b  <= (state_d == IDLE) || (state_d == DONE);
            RAMOE_b  <= (state_d != RD);
            RAMWE_b  <= (state_d != WR_STROBE);
            drive_en <= state_d inside {WR_SETUP, WR_STROBE, WR_HOLD};
            cpu_ack  <= (state_d == DONE) && (owner_q == OWN_CPU);
            vid_ack  <= (state_d == DONE) && (owner_q == OWN_VID);
            if (state_q == RD && state_d == DONE) begin
                if (owner_q == OWN_VID) begin
                    vid_rdata <= DAT;
                end else begin
                    cpu_rdata <= DAT;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural async SRAM plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int AW     = 18;
    localparam int DW     = 8;
    localparam int RDC    = 2;
    localparam int WRC    = 2;
    localparam int RD_LAT = RDC + 1;
    localparam int WR_LAT = WRC + 3;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic          vid_ack;
    logic          RAMCS_b;
    logic          RAMOE_b;
    logic          RAMWE_b;
    logic [AW-1:0] ADR;
    wire  [DW-1:0] DAT;

    int checks = 0;
    int errors = 0;
    bit last_vid = 1'b0;

    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .vid_ack   (vid_ack),
        .RAMCS_b   (RAMCS_b),
        .RAMOE_b   (RAMOE_b),
        .RAMWE_b   (RAMWE_b),
        .ADR       (ADR),
        .DAT       (DAT)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 32'h00DE) return 8'h3C;
        return 8'(a * 37 + (a >> 8) * 11 + 5);
    endfunction

    function automatic logic [DW-1:0] ref_rd(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    // Async SRAM: drives data while selected and read-enabled, writes on rising WE.
    assign DAT = (!RAMCS_b && !RAMOE_b && RAMWE_b) ? sram[ADR] : 'z;

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = init_val(i);
        forever begin
            @(posedge RAMWE_b);
            if (!RAMCS_b && reset_b) sram[ADR] = DAT;
        end
    end

    always @(negedge clk) begin
        if (reset_b) begin
            checks++;
            if (!RAMWE_b && (RAMCS_b || !RAMOE_b)) begin
                errors++;
                $display("[TB] FAIL we_strobe_qual got cs=%0b oe=%0b expected cs=0 oe=1", RAMCS_b, RAMOE_b);
            end
            checks++;
            if (dut.drive_en && !RAMOE_b) begin
                errors++;
                $display("[TB] FAIL bus_contention got drive_en=1 oe=0 expected no overlap");
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    task automatic access(input bit vid, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd);
        lat = -1;
        rd  = '0;
        @(negedge clk);
        if (vid) begin
            vid_req  = 1'b1;
            vid_addr = addr;
        end else begin
            cpu_req   = 1'b1;
            cpu_we    = we;
            cpu_addr  = addr;
            cpu_wdata = wd;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (vid ? vid_ack : cpu_ack) begin
                lat = n;
                rd  = vid ? vid_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
    endtask

    task automatic access_pair(input bit cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                               input logic [AW-1:0] va, output int clat, output int vlat,
                               output logic [DW-1:0] crd, output logic [DW-1:0] vrd);
        clat = -1;
        vlat = -1;
        crd  = '0;
        vrd  = '0;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = cwe;
        cpu_addr  = ca;
        cpu_wdata = cwd;
        vid_req   = 1'b1;
        vid_addr  = va;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (cpu_ack && clat < 0) begin
                clat    = n;
                crd     = cpu_rdata;
                cpu_req = 1'b0;
            end
            if (vid_ack && vlat < 0) begin
                vlat    = n;
                vrd     = vid_rdata;
                vid_req = 1'b0;
            end
            if (clat >= 0 && vlat >= 0) break;
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({RAMCS_b, RAMOE_b, RAMWE_b} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_strobes got %b expected 111", {RAMCS_b, RAMOE_b, RAMWE_b});
        end
        checks++;
        if (ADR !== '0) begin
            errors++;
            $display("[TB] FAIL reset_adr got %0h expected 0", ADR);
        end
        checks++;
        if ({cpu_ack, vid_ack} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_acks got %b expected 00", {cpu_ack, vid_ack});
        end
        checks++;
        if (cpu_rdata !== '0 || vid_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got %0h/%0h expected 0/0", cpu_rdata, vid_rdata);
        end
        checks++;
        if (dut.drive_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_drive got %b expected 0", dut.drive_en);
        end
        reset_b  = 1'b1;
        last_vid = 1'b0;
    endtask

    task automatic test_cpu_write_read();
        int lat;
        logic [DW-1:0] rd;
        access(1'b0, 1'b1, 18'h01234, 8'hA5, lat, rd);
        ref_mem[32'h1234] = 8'hA5;
        last_vid = 1'b0;
        checks++;
        if (lat != WR_LAT) begin
            errors++;
            $display("[TB] FAIL write_latency got %0d expected %0d", lat, WR_LAT);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_ack_pulse got %b expected 0", cpu_ack);
        end
        access(1'b0, 1'b0, 18'h01234, 8'h00, lat, rd);
        checks++;
        if (lat != RD_LAT) begin
            errors++;
            $display("[TB] FAIL read_latency got %0d expected %0d", lat, RD_LAT);
        end
        checks++;
        if (rd !== ref_rd(32'h1234)) begin
            errors++;
            $display("[TB] FAIL read_data got %0h expected %0h", rd, ref_rd(32'h1234));
        end
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 8'hA5 || cpu_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_hold got %0h ack=%b expected a5 ack=0", cpu_rdata, cpu_ack);
        end
    endtask

    task automatic test_vid_read();
        int lat;
        logic [DW-1:0] rd;
        logic [DW-1:0] cpu_before;
        cpu_before = cpu_rdata;
        access(1'b1, 1'b0, 18'h000DE, 8'h00, lat, rd);
        last_vid = 1'b1;
        checks++;
        if (lat != RD_LAT || rd !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL vid_read got lat=%0d data=%0h expected lat=%0d data=3c", lat, rd, RD_LAT);
        end
        @(negedge clk);
        checks++;
        if (vid_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vid_ack_pulse got %b expected 0", vid_ack);
        end
        checks++;
        if (cpu_rdata !== cpu_before) begin
            errors++;
            $display("[TB] FAIL vid_isolation got %0h expected %0h", cpu_rdata, cpu_before);
        end
    endtask

    task automatic test_simultaneous();
        int lat;
        int clat;
        int vlat;
        logic [DW-1:0] rd;
        logic [DW-1:0] crd;
        logic [DW-1:0] vrd;
        access(1'b0, 1'b0, 18'h00055, 8'h00, lat, rd);
        last_vid = 1'b0;
        access_pair(1'b0, 18'h01234, 8'h00, 18'h000DE, clat, vlat, crd, vrd);
        checks++;
        if (vlat != RD_LAT || clat != 2 * RD_LAT + 1) begin
            errors++;
            $display("[TB] FAIL simul_order got vid=%0d cpu=%0d expected vid=%0d cpu=%0d",
                     vlat, clat, RD_LAT, 2 * RD_LAT + 1);
        end
        checks++;
        if (crd !== ref_rd(32'h1234) || vrd !== ref_rd(32'hDE)) begin
            errors++;
            $display("[TB] FAIL simul_data got %0h/%0h expected %0h/%0h",
                     crd, vrd, ref_rd(32'h1234), ref_rd(32'hDE));
        end
        last_vid = 1'b0;
    endtask

    task automatic test_alternate();
        int order[$];
        int when[$];
        bit first_vid;
        first_vid = !last_vid;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 18'h01234;
        vid_req  = 1'b1;
        vid_addr = 18'h000DE;
        for (int n = 1; n <= 100 && order.size() < 8; n++) begin
            @(negedge clk);
            if (cpu_ack) begin
                order.push_back(0);
                when.push_back(n);
            end
            if (vid_ack) begin
                order.push_back(1);
                when.push_back(n);
            end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        checks++;
        if (order.size() != 8) begin
            errors++;
            $display("[TB] FAIL alt_count got %0d expected 8", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != int'(first_vid ^ i[0])) begin
                errors++;
                $display("[TB] FAIL alt_order[%0d] got %0d expected %0d", i, order[i], int'(first_vid ^ i[0]));
            end
            checks++;
            if ((i == 0 && when[i] != RD_LAT) || (i > 0 && when[i] - when[i-1] != RD_LAT + 1)) begin
                errors++;
                $display("[TB] FAIL alt_spacing[%0d] got %0d expected %0d", i,
                         (i == 0) ? when[i] : when[i] - when[i-1], (i == 0) ? RD_LAT : RD_LAT + 1);
            end
        end
        last_vid = first_vid ^ 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int mode;
            int lat;
            int clat;
            int vlat;
            int cl;
            bit cwe;
            bit vid_first;
            logic [AW-1:0] ca;
            logic [AW-1:0] va;
            logic [DW-1:0] cwd;
            logic [DW-1:0] rd;
            logic [DW-1:0] crd;
            logic [DW-1:0] vrd;
            logic [DW-1:0] exp_c;
            logic [DW-1:0] exp_v;
            mode = $urandom_range(0, 2);
            cwe  = 1'($urandom_range(0, 1));
            ca   = AW'(32'h100 + $urandom_range(0, 7));
            va   = AW'(32'h100 + $urandom_range(0, 7));
            cwd  = 8'($urandom);
            cl   = cwe ? WR_LAT : RD_LAT;
            if (mode == 0) begin
                exp_c = ref_rd(int'(ca));
                access(1'b0, cwe, ca, cwd, lat, rd);
                if (cwe) ref_mem[int'(ca)] = cwd;
                last_vid = 1'b0;
                checks++;
                if (lat != cl || (!cwe && rd !== exp_c)) begin
                    errors++;
                    $display("[TB] FAIL rand_cpu[%0d] got lat=%0d data=%0h expected lat=%0d data=%0h",
                             it, lat, rd, cl, exp_c);
                end
            end else if (mode == 1) begin
                exp_v = ref_rd(int'(va));
                access(1'b1, 1'b0, va, 8'h00, lat, rd);
                last_vid = 1'b1;
                checks++;
                if (lat != RD_LAT || rd !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL rand_vid[%0d] got lat=%0d data=%0h expected lat=%0d data=%0h",
                             it, lat, rd, RD_LAT, exp_v);
                end
            end else begin
                vid_first = !last_vid;
                exp_c = ref_rd(int'(ca));
                if (vid_first) begin
                    exp_v = ref_rd(int'(va));
                    if (cwe) ref_mem[int'(ca)] = cwd;
                end else begin
                    if (cwe) ref_mem[int'(ca)] = cwd;
                    exp_v = ref_rd(int'(va));
                end
                access_pair(cwe, ca, cwd, va, clat, vlat, crd, vrd);
                last_vid = !vid_first;
                checks++;
                if (vid_first ? (vlat != RD_LAT || clat != RD_LAT + 1 + cl)
                              : (clat != cl || vlat != cl + 1 + RD_LAT)) begin
                    errors++;
                    $display("[TB] FAIL rand_pair_lat[%0d] got cpu=%0d vid=%0d vid_first=%0b",
                             it, clat, vlat, vid_first);
                end
                checks++;
                if (vrd !== exp_v || (!cwe && crd !== exp_c)) begin
                    errors++;
                    $display("[TB] FAIL rand_pair_data[%0d] got %0h/%0h expected %0h/%0h",
                             it, crd, vrd, exp_c, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat;
        int acks;
        logic [DW-1:0] rd;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 18'h00155;
        cpu_wdata = 8'h77;
        repeat (2) @(negedge clk);
        checks++;
        if (RAMWE_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_in_strobe got we=%b expected 0", RAMWE_b);
        end
        reset_b = 1'b0;
        #1;
        checks++;
        if ({RAMWE_b, RAMCS_b, RAMOE_b, dut.drive_en} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL abort_pins got we/cs/oe/drv=%b expected 1110",
                     {RAMWE_b, RAMCS_b, RAMOE_b, dut.drive_en});
        end
        cpu_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || vid_ack) acks++;
        end
        reset_b  = 1'b1;
        last_vid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || vid_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_ack got %0d acks expected 0", acks);
        end
        access(1'b0, 1'b0, 18'h3FFFF, 8'h00, lat, rd);
        checks++;
        if (lat != RD_LAT || rd !== ref_rd(32'h3FFFF)) begin
            errors++;
            $display("[TB] FAIL post_reset_read got lat=%0d data=%0h expected lat=%0d data=%0h",
                     lat, rd, RD_LAT, ref_rd(32'h3FFFF));
        end
    endtask

    task automatic test_addr_change();
        int lat;
        logic [DW-1:0] rd;
        lat = -1;
        rd  = '0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 18'h20000;
        @(negedge clk);
        cpu_addr = 18'h00000;
        checks++;
        if (ADR !== 18'h20000) begin
            errors++;
            $display("[TB] FAIL addr_latch_g1 got %0h expected 20000", ADR);
        end
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = n;
                rd  = cpu_rdata;
                break;
            end
        end
        cpu_req  = 1'b0;
        last_vid = 1'b0;
        checks++;
        if (lat != RD_LAT || rd !== ref_rd(32'h20000)) begin
            errors++;
            $display("[TB] FAIL addr_latch_read got lat=%0d data=%0h expected lat=%0d data=%0h",
                     lat, rd, RD_LAT, ref_rd(32'h20000));
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ADR !== 18'h20000) begin
            errors++;
            $display("[TB] FAIL addr_idle_hold got %0h expected 20000", ADR);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_vid_read();
        test_simultaneous();
        test_alternate();
        test_random();
        test_reset_mid_write();
        test_addr_change();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
